cla_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/logic unit for the processor ALU. Successor to the fixed 32-bit combinational CLA: configurable width, one lookahead block per pipeline stage, add/subtract/AND/OR, full flag set (zero, negative, carry, signed overflow) and a valid/ready handshake with backpressure. It sits between operand select and writeback in the execute stage.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_block.sv | 36 +++
 rtl/cla_pipe.sv | 197 +++++++++++++++++++
 tb/tb_cla_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/logic unit.
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  // Width-independent control carried by every stage register.
  // carry: carry into the block this stage resolves next.
  // zero:  all result bits finished so far are zero.
  typedef struct packed {
    logic vld;
    op_e  op;
    logic carry;
    logic zero;
  } stage_ctl_t;

  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-wide carry-lookahead slice.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;
  logic             gg, pp;

  // Every carry comes from the group generate/propagate of bits [i:0] and cin,
  // never from the neighbouring carry, so depth grows with the prefix only.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      gg     = g[i] | (p[i] & gg);
      pp     = pp & p[i];
      c[i+1] = gg | (pp & cin);
    end
    sum   = p ^ c[BLOCK-1:0];
    cout  = c[BLOCK];
    c_msb = c[BLOCK-1];
  end

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/logic unit: one BLOCK-wide lookahead slice
// per stage, whole-pipe stall on output backpressure, registered outputs.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int LAST = NBLK - 1;

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("cla_pipe: WIDTH must be a multiple of BLOCK");
  end

  logic             advance;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // The pipe moves as one unit whenever the output slot can be vacated.
  assign advance  = !out_vld_q || out_ready;
  assign in_ready = advance;

  // Stage k resolves bits [k*BLOCK +: BLOCK]. Stage 0 works directly on the
  // ports; stage k>0 owns a register holding the still-unprocessed operand
  // bits, the finished low result bits and the running carry/zero.
  for (genvar k = 0; k < NBLK; k++) begin : stg
    localparam int RW = WIDTH - k * BLOCK;   // operand bits from this block up
    localparam int DW = (k + 1) * BLOCK;     // result bits done after this stage

    stage_ctl_t       ctl_cur;
    logic [TAG_W-1:0] tag_cur;
    logic [RW-1:0]    a_cur, b_cur;
    logic [DW-1:0]    res_nxt;
    logic [BLOCK-1:0] sum, blk_res;
    logic             cout, cmsb, carry_nxt, zero_nxt;

    if (k == 0) begin : g_src
      // SUB becomes A + ~B + 1; logic ops start with carry 0.
      always_comb begin
        ctl_cur       = '0;
        ctl_cur.vld   = in_valid;
        ctl_cur.op    = op_e'(in_op);
        ctl_cur.carry = (in_op == OP_SUB) | ((in_op == OP_ADD) & in_cin);
        ctl_cur.zero  = 1'b1;
        tag_cur       = in_tag;
        a_cur         = in_a;
        b_cur         = (in_op == OP_SUB) ? ~in_b : in_b;
        res_nxt       = blk_res;
      end
    end else begin : g_src
      stage_ctl_t         ctl_d, ctl_q;
      logic [TAG_W-1:0]   tag_d, tag_q;
      logic [RW-1:0]      a_d, a_q, b_d, b_q;
      logic [k*BLOCK-1:0] res_d, res_q;

      // Capture the previous stage's outputs when the pipe moves, else hold.
      always_comb begin
        ctl_d = ctl_q;
        tag_d = tag_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        if (advance) begin
          ctl_d       = stg[k-1].ctl_cur;
          ctl_d.carry = stg[k-1].carry_nxt;
          ctl_d.zero  = stg[k-1].zero_nxt;
          tag_d       = stg[k-1].tag_cur;
          a_d         = stg[k-1].a_cur[RW+BLOCK-1:BLOCK];
          b_d         = stg[k-1].b_cur[RW+BLOCK-1:BLOCK];
          res_d       = stg[k-1].res_nxt;
        end
      end

      // Stage register; reset empties the slot and flushes its operation.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          ctl_q <= '0;
          tag_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
          res_q <= '0;
        end else begin
          ctl_q <= ctl_d;
          tag_q <= tag_d;
          a_q   <= a_d;
          b_q   <= b_d;
          res_q <= res_d;
        end
      end

      // Present the registered state to this stage's block logic.
      always_comb begin
        ctl_cur = ctl_q;
        tag_cur = tag_q;
        a_cur   = a_q;
        b_cur   = b_q;
        res_nxt = {blk_res, res_q};
      end
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a     (a_cur[BLOCK-1:0]),
      .b     (b_cur[BLOCK-1:0]),
      .cin   (ctl_cur.carry),
      .sum   (sum),
      .cout  (cout),
      .c_msb (cmsb)
    );

    // Select this block's result by op and fold it into carry and zero.
    always_comb begin
      blk_res = sum;
      case (ctl_cur.op)
        OP_AND:  blk_res = a_cur[BLOCK-1:0] & b_cur[BLOCK-1:0];
        OP_OR:   blk_res = a_cur[BLOCK-1:0] | b_cur[BLOCK-1:0];
        default: blk_res = sum;
      endcase
      carry_nxt = is_arith(ctl_cur.op) & cout;
      zero_nxt  = ctl_cur.zero & ~|blk_res;
    end

    // Only the top block's carry into its MSB feeds the overflow flag.
    if (k < LAST) begin : g_mid
      logic cmsb_unused;
      assign cmsb_unused = cmsb;
    end
  end

  // Output slot: load the finished operation when the pipe moves.
  always_comb begin
    out_vld_d = out_vld_q;
    res_d     = res_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    tag_d     = tag_q;
    if (advance) begin
      out_vld_d = stg[LAST].ctl_cur.vld;
      res_d     = stg[LAST].res_nxt;
      cout_d    = stg[LAST].carry_nxt;
      ovf_d     = is_arith(stg[LAST].ctl_cur.op) & (stg[LAST].cout ^ stg[LAST].cmsb);
      zero_d    = stg[LAST].zero_nxt;
      tag_d     = stg[LAST].tag_cur;
    end
  end

  // Output register; reset clears the result and every flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_vld_q <= 1'b0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      tag_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      res_q     <= res_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      tag_q     <= tag_d;
    end
  end

  assign out_valid  = out_vld_q;
  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign out_neg    = res_q[WIDTH-1];
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: directed corner cases, backpressure, random ADD/SUB
// against an arithmetic reference model, and mid-stream reset.
module tb_cla_pipe;

  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout, out_ovf, out_zero, out_neg;
  logic [TAG_W-1:0] out_tag;

  cla_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_neg(out_neg), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        cout, ovf, zero, neg;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   popped = 0;
  int   flushed_seen = 0;
  bit   flush_watch = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain 32/33-bit arithmetic; overflow from operand and result signs.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic [3:0] tag);
    exp_t e;
    logic [32:0] wide;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (op)
      2'd0: begin
        wide   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        e.res  = wide[31:0];
        e.cout = wide[32];
        e.ovf  = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      2'd1: begin
        e.res  = a - b;
        e.cout = (a >= b);
        e.ovf  = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      2'd2: e.res = a & b;
      default: e.res = a | b;
    endcase
    e.zero = (e.res == 32'd0);
    e.neg  = e.res[31];
    e.tag  = tag;
    return e;
  endfunction

  // Called at a negedge after inputs are driven; resolves both handshakes
  // for the coming posedge, then advances to the next negedge.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    acc = 0;
    if (flush_watch && out_valid && (out_tag inside {4'hA, 4'hB, 4'hC})) flushed_seen++;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        popped++;
        chk("sb_tag", out_tag, e.tag);
        chk("sb_res", out_result, e.res);
        chk("sb_flags", {out_cout, out_ovf, out_zero, out_neg}, {e.cout, e.ovf, e.zero, e.neg});
      end
    end
    if (reset_n && in_valid && in_ready) begin
      exp_q.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
      acc = 1;
    end
    @(negedge clock);
  endtask

  // One isolated operation: latency and literal expectations plus scoreboard.
  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [3:0] tag,
                         input logic [31:0] xres, input logic [3:0] xflags);
    bit acc;
    int lat;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_cin = cin; in_tag = tag;
    out_ready = 1;
    cycle(acc);
    chk({name, "_acc"}, acc, 1'b1);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle(acc);
      lat++;
    end
    chk({name, "_lat"}, lat, 4);
    chk({name, "_res"}, out_result, xres);
    chk({name, "_flags"}, {out_cout, out_ovf, out_zero, out_neg}, xflags);
    cycle(acc);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc;
    int idx, i, p0;

    // Reset: two cycles low
    reset_n = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_cin = 0; in_tag = 0;
    out_ready = 1;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {out_cout, out_ovf, out_zero, out_neg}, 4'b0000);
    chk("rst_tag", out_tag, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset_n = 1;
    cycle(acc);

    // Directed corners; flags are {cout, ovf, zero, neg}
    run_one("add_ovf",    2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h1, 32'h8000_0000, 4'b0101);
    run_one("add_ripple", 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'h2, 32'h0000_0000, 4'b1010);
    run_one("sub_eq",     2'd1, 32'd5,         32'd5,         1'b0, 4'h3, 32'h0000_0000, 4'b1010);
    run_one("and",        2'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 4'h4, 32'h00F0_00F0, 4'b0000);
    run_one("or",         2'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 4'h5, 32'hFFF0_FFF0, 4'b0001);
    run_one("sub_borrow", 2'd1, 32'd0,         32'd1,         1'b1, 4'h6, 32'hFFFF_FFFF, 4'b0001);
    run_one("sub_ovf",    2'd1, 32'h8000_0000, 32'd1,         1'b0, 4'h7, 32'h7FFF_FFFF, 4'b1100);

    // Backpressure: 8 back-to-back ops, out_ready low in cycles 6..8
    idx = 0; i = 0; p0 = popped;
    in_op = 2'($urandom_range(0, 1)); in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    while ((idx < 8 || exp_q.size() > 0) && i < 40) begin
      in_valid  = (idx < 8);
      in_tag    = 4'(idx);
      out_ready = !(i >= 6 && i <= 8);
      #1;
      chk("bp_in_ready", in_ready, !(i >= 6 && i <= 8));
      cycle(acc);
      if (acc) begin
        idx++;
        in_op = 2'($urandom_range(0, 1)); in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
      end
      i++;
    end
    chk("bp_results", popped - p0, 8);

    // Random ADD/SUB with random gaps and backpressure
    idx = 0; i = 0; p0 = popped; in_valid = 0;
    while ((idx < 25 || exp_q.size() > 0) && i < 600) begin
      if (!in_valid && idx < 25 && $urandom_range(0, 3) != 0) begin
        in_valid = 1;
        in_op = 2'($urandom_range(0, 1)); in_a = pick_operand(); in_b = pick_operand();
        in_cin = 1'($urandom); in_tag = 4'(idx);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) begin
        idx++;
        in_valid = 0;
      end
      i++;
    end
    chk("rand_results", popped - p0, 25);

    // Reset mid-stream with 3 operations in flight
    out_ready = 1;
    flush_watch = 1;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1; in_op = 2'd0; in_a = $urandom; in_b = $urandom; in_cin = 0;
      in_tag = 4'(4'hA + t);
      cycle(acc);
    end
    in_valid = 0;
    reset_n = 0;
    cycle(acc);
    reset_n = 1;
    exp_q.delete();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    run_one("post_flush", 2'd0, 32'h1234_5678, 32'h1111_1111, 1'b1, 4'h3, 32'h2345_678A, 4'b0000);
    repeat (8) cycle(acc);
    chk("flushed_tags", flushed_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
